// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster timing constants, sync polarity codes
// and count types for the VGA pixel-domain stages.
package vga_timing_pkg;

   localparam int CNT_W    = 10;
   localparam int FCNT_W   = 16;

   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic SYNC_ACT_LOW  = 1'b0;
   localparam logic SYNC_ACT_HIGH = 1'b1;

   typedef logic [CNT_W-1:0]  cnt_t;
   typedef logic [FCNT_W-1:0] fcnt_t;

   typedef struct packed {
      logic de;
      logic hsync;
      logic vsync;
   } sync_bus_t;

endpackage

// File: rtl/sync_delay_line.sv
// Depth-DEPTH shift register realigning {de,hsync,vsync} with the
// registered RGB stage. Ports: clk_pix, resetn (sync, active-low),
// din[W], dout[W]. DEPTH=0 is a combinational pass-through.
module sync_delay_line #(
   parameter int           DEPTH   = 1,
   parameter int           W       = 3,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk_pix,
   input  logic         resetn,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   if (DEPTH < 0 || DEPTH > 4) begin : g_bad_depth
      $error("sync_delay_line: DEPTH must be 0..4");
   end

   if (DEPTH == 0) begin : g_thru
      assign dout = din;
   end else begin : g_sr
      logic [W-1:0] stage [DEPTH];

      always_ff @(posedge clk_pix) begin
         if (!resetn) begin
            for (int i = 0; i < DEPTH; i++)
               stage[i] <= RST_VAL;
         end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++)
               stage[i] <= stage[i-1];
         end
      end

      assign dout = stage[DEPTH-1];
   end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: hcount/vcount/de, syncs, line/frame
// strobes and a PIPE_DLY-deep delayed copy of {de,hsync,vsync}.
// Ports: clk_pix, resetn (sync, active-low), en; outputs hcount,
// vcount, de, hsync, vsync, line_start, frame_start, de_q, hsync_q,
// vsync_q, and frame_cnt when VGA_SYNC_FRAMECNT_EN is defined.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int   H_ACTIVE = vga_timing_pkg::H_ACTIVE,
   parameter int   H_FP     = vga_timing_pkg::H_FP,
   parameter int   H_SYNC   = vga_timing_pkg::H_SYNC,
   parameter int   H_BP     = vga_timing_pkg::H_BP,
   parameter int   V_ACTIVE = vga_timing_pkg::V_ACTIVE,
   parameter int   V_FP     = vga_timing_pkg::V_FP,
   parameter int   V_SYNC   = vga_timing_pkg::V_SYNC,
   parameter int   V_BP     = vga_timing_pkg::V_BP,
   parameter logic SYNC_POL = SYNC_ACT_LOW,
   parameter int   PIPE_DLY = 1
) (
   input  logic              clk_pix,
   input  logic              resetn,
   input  logic              en,
   output logic [CNT_W-1:0]  hcount,
   output logic [CNT_W-1:0]  vcount,
   output logic              de,
   output logic              hsync,
   output logic              vsync,
   output logic              line_start,
   output logic              frame_start,
   output logic              de_q,
   output logic              hsync_q,
   output logic              vsync_q
`ifdef VGA_SYNC_FRAMECNT_EN
  ,output logic [FCNT_W-1:0] frame_cnt
`endif
);

   localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_total
      $error("vga_sync_gen: raster totals must be <= 1024");
   end

   localparam cnt_t H_LAST = cnt_t'(H_TOT - 1);
   localparam cnt_t V_LAST = cnt_t'(V_TOT - 1);
   localparam cnt_t H_ACT  = cnt_t'(H_ACTIVE);
   localparam cnt_t V_ACT  = cnt_t'(V_ACTIVE);
   localparam cnt_t HS_BEG = cnt_t'(H_ACTIVE + H_FP);
   localparam cnt_t HS_END = cnt_t'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam cnt_t VS_BEG = cnt_t'(V_ACTIVE + V_FP);
   localparam cnt_t VS_END = cnt_t'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic h_wrap;
   logic v_wrap;
   cnt_t h_nxt;
   cnt_t v_nxt;
   logic de_nxt;
   logic hs_nxt;
   logic vs_nxt;

   // All registered outputs are decoded from the next counts so they
   // land in the same cycle as the pixel they describe.
   always_comb begin
      h_wrap = (hcount == H_LAST);
      v_wrap = (vcount == V_LAST);
      h_nxt  = h_wrap ? '0 : hcount + cnt_t'(1);
      v_nxt  = vcount;
      if (h_wrap)
         v_nxt = v_wrap ? '0 : vcount + cnt_t'(1);
      de_nxt = (h_nxt < H_ACT) && (v_nxt < V_ACT);
      hs_nxt = (h_nxt >= HS_BEG && h_nxt <= HS_END) ?
               SYNC_POL : ~SYNC_POL;
      vs_nxt = (v_nxt >= VS_BEG && v_nxt <= VS_END) ?
               SYNC_POL : ~SYNC_POL;
   end

   always_ff @(posedge clk_pix) begin
      if (!resetn) begin
         hcount      <= H_LAST;
         vcount      <= V_LAST;
         de          <= 1'b0;
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         if (en) begin
            hcount      <= h_nxt;
            vcount      <= v_nxt;
            de          <= de_nxt;
            hsync       <= hs_nxt;
            vsync       <= vs_nxt;
            line_start  <= (h_nxt == '0);
            frame_start <= (h_nxt == '0) && (v_nxt == '0);
         end
      end
   end

   sync_bus_t dly_in;
   sync_bus_t dly_out;

   assign dly_in = '{de: de, hsync: hsync, vsync: vsync};

   // Delay stages keep shifting while en is low, so the
   // delayed copies settle onto the held raster values.
   sync_delay_line #(
      .DEPTH   (PIPE_DLY),
      .W       (3),
      .RST_VAL ({1'b0, ~SYNC_POL, ~SYNC_POL})
   ) u_dly (
      .clk_pix (clk_pix),
      .resetn  (resetn),
      .din     (dly_in),
      .dout    (dly_out)
   );

   assign de_q    = dly_out.de;
   assign hsync_q = dly_out.hsync;
   assign vsync_q = dly_out.vsync;

`ifdef VGA_SYNC_FRAMECNT_EN
   always_ff @(posedge clk_pix) begin
      if (!resetn)
         frame_cnt <= '0;
      else if (frame_start)
         frame_cnt <= frame_cnt + fcnt_t'(1);
   end
`endif

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Raster timing generator for the 640x480@60 Hz VGA path, running in the ~25 MHz pixel domain. It produces the `hcount`/`vcount`/`de` raster coordinates consumed directly by the pixel test-pattern stage. It also produces sync pulses plus line/frame strobes, and a programmable delay line that realigns `hsync`/`vsync`/`de` with the registered RGB output of the downstream stage.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync width (pixels)
- `H_BP`, 48, horizontal back porch; H_TOTAL = 800
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BP`, 33, vertical back porch; V_TOTAL = 525
- `SYNC_POL`, 0, sync active level (0 = active-low)
- `PIPE_DLY`, 1, delay-line depth in cycles, legal 0..4
- `clk_pix  in  1  pixel clock`
- `resetn  in  1  reset; synchronous, active-low; clock clk_pix`
- `en  in  1  raster advance enable`
- `hcount  out  10  current pixel column, 0..H_TOTAL-1`
- `vcount  out  10  current line, 0..V_TOTAL-1`
- `de  out  1  high when hcount<H_ACTIVE and vcount<V_ACTIVE`
- `hsync  out  1  horizontal sync, aligned with hcount`
- `vsync  out  1  vertical sync, aligned with vcount`
- `line_start  out  1  one-cycle strobe when hcount becomes 0`
- `frame_start  out  1  one-cycle strobe when (hcount,vcount) becomes (0,0)`
- `de_q`, `hsync_q`, `vsync_q  out  1 each  de/hsync/vsync delayed PIPE_DLY cycles`
- `frame_cnt  out  16  frame counter (only with macro, see Configuration)`

## Operation
- hcount increments each enabled cycle. At H_TOTAL-1 it wraps to 0 and vcount increments. vcount wraps to 0 after V_TOTAL-1.
- All of hcount, vcount, de, hsync, vsync, line_start and frame_start are registered. They are computed from next-count values so that every output describes the same pixel in the same cycle. No output lags hcount.
- hsync is active for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
- vsync is active for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491, across whole lines.
- Active level of both syncs = SYNC_POL.
- `en`=0: counters and de/hsync/vsync hold; line_start and frame_start forced 0. The delay line keeps shifting, so after PIPE_DLY cycles its outputs also settle to the held values.
- PIPE_DLY=0: the `_q` outputs are combinational copies of de/hsync/vsync.
- All counter arithmetic is unsigned 10-bit. Comparisons use parameter-derived constants. Totals must be ≤1024, checked by an elaboration-time assertion.

## Timing
- Reset state (resetn=0 at a clk_pix edge):
  - hcount=H_TOTAL-1 (799), vcount=V_TOTAL-1 (524); this is the last pixel of the frame, in blanking.
  - de=0; hsync and vsync at inactive level (!SYNC_POL).
  - line_start=0, frame_start=0.
  - All delay stages: de 0, syncs inactive. frame_cnt=0.
- First enabled cycle after reset release: hcount=0, vcount=0, de=1, line_start=1, frame_start=1.
- Reset asserted mid-frame: returns to the reset state on the next edge, and the delay-line contents are flushed.
- End of line (799→0): vcount increments in the same edge; line_start=1 for exactly one cycle.
- End of frame (799,524 → 0,0): line_start and frame_start are both 1 in that cycle.
- en toggling at a wrap boundary: a wrap occurs only on an edge where en=1. Strobes fire only on that edge.
- `_q` outputs: exactly PIPE_DLY clk_pix edges after the corresponding undelayed output.

## Configuration
- `VGA_SYNC_FRAMECNT_EN` defined: `frame_cnt` port exists. It increments on every edge where frame_start is set, wraps 0xFFFF→0x0000, and resets to 0.
- Macro undefined: `frame_cnt` port and its counter are absent. All other behaviour is identical.

## Structure
- Shared package `vga_timing_pkg`: 640x480@60 constants (H_ACTIVE…V_BP, H_TOTAL, V_TOTAL), sync polarity constants, and the count width (10). The downstream pattern stage imports the same package.
- One sub-module: `sync_delay_line`, a parameterized depth-N, width-3 shift register with synchronous active-low reset to a configurable reset vector. It is used for {de, hsync, vsync}.

## Test plan
- Reset hold for 3 cycles, then release with en=1:
  - During reset: hcount=799, vcount=524, de=0, hsync=vsync=1.
  - First cycle after release: (0,0), de=1, frame_start=1.
- Run one line:
  - de=1 for hcount 0..639, 0 at 640..799.
  - hsync=0 exactly for 656..751, i.e. 96 cycles.
  - line_start pulses once per 800 cycles.
- Run a full frame:
  - vsync=0 for lines 490..491 (1600 cycles).
  - frame_start recurs after exactly 420000 cycles.
  - de high for 307200 cycles.
- Drop en for 10 cycles at hcount=799:
  - All counts hold; no strobes.
  - On en=1: wraps to hcount=0, vcount+1, with line_start=1.
- PIPE_DLY=2, random en: de_q/hsync_q/vsync_q equal the undelayed outputs from 2 cycles earlier, with no mismatch over 2 frames.
- With VGA_SYNC_FRAMECNT_EN and frame_cnt preloaded via force to 0xFFFF: next frame_start → frame_cnt=0x0000.
